// File: rtl/adder_pkg.sv
// Shared constants and types for the registered adder.
package adder_pkg;

  localparam int ADDER_DEF_WIDTH = 2;

  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

  typedef logic [ADDER_DEF_WIDTH:0] adder_sum_t;

endpackage

// File: rtl/adder_pipe_reg.sv
// Generic W-bit pipeline flop, async active-low clear to zero.
module adder_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/adder_reg.sv
// Registered unsigned adder, sum is WIDTH+1 bits so the carry is never lost.
// ADDER_IN_REG_EN adds an operand register stage (latency 2 instead of 1).
module adder_reg
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic [sum_width(WIDTH)-1:0] sum,
  output logic                        sum_vld
);

  localparam int SW = sum_width(WIDTH);
`ifdef ADDER_IN_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [WIDTH-1:0] op_a, op_b;
  logic [SW-1:0]    sum_d;
  logic [STAGES:0]  vld_pipe;

`ifdef ADDER_IN_REG_EN
  adder_pipe_reg #(.W(WIDTH)) u_a_reg (.clk(clk), .rst(rst), .d(a), .q(op_a));
  adder_pipe_reg #(.W(WIDTH)) u_b_reg (.clk(clk), .rst(rst), .d(b), .q(op_b));
`else
  assign op_a = a;
  assign op_b = b;
`endif

  assign sum_d = {1'b0, op_a} + {1'b0, op_b};

  adder_pipe_reg #(.W(SW)) u_sum_reg (.clk(clk), .rst(rst), .d(sum_d), .q(sum));

  // A constant 1 marches through the stages after reset release; once it
  // reaches the end it stays there until the next reset.
  assign vld_pipe[0] = 1'b1;
  for (genvar s = 0; s < STAGES; s++) begin : g_vld
    adder_pipe_reg #(.W(1)) u_vld_reg (
      .clk(clk), .rst(rst), .d(vld_pipe[s]), .q(vld_pipe[s+1])
    );
  end
  assign sum_vld = vld_pipe[STAGES];

endmodule

// File: tb/tb_adder_reg.sv
// Self-checking bench for adder_reg; works in the default and ADDER_IN_REG_EN builds.
module tb_adder_reg;

  localparam int WIDTH = 2;
`ifdef ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH:0]   sum;
  logic             sum_vld;

  int checks = 0;
  int errors = 0;

  // Reference model: expected sums in capture order, plus edges since release.
  int             exp_q[$];
  int             edges;
  logic [WIDTH:0] exp_sum;
  logic           exp_vld;

  adder_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum), .sum_vld(sum_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(0);
    edges = 0;
  endtask

  // One rising edge: record operands seen at the edge, then sample 1 ns later.
  task automatic tick();
    exp_q.push_back(int'(a) + int'(b));
    @(posedge clk); #1;
    edges++;
    exp_sum = (WIDTH+1)'(exp_q.pop_front());
    exp_vld = (edges >= LAT);
  endtask

  task automatic test_reset();
    rst = 1'b0; a = 2'd3; b = 2'd3;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (sum !== '0 || sum_vld !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold sum=%0d vld=%b expected sum=0 vld=0", sum, sum_vld);
      end
    end
    #3 rst = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      checks++;
      if (sum !== exp_sum || sum_vld !== exp_vld) begin
        errors++;
        $display("FAIL reset_release edge=%0d sum=%0d vld=%b expected sum=%0d vld=%b",
                 edges, sum, sum_vld, exp_sum, exp_vld);
      end
    end
    checks++;
    if (sum !== 3'd6 || sum_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_result sum=%0d vld=%b expected sum=6 vld=1", sum, sum_vld);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] va[3] = '{2'd0, 2'd1, 2'd2};
    logic [WIDTH-1:0] vb[3] = '{2'd1, 2'd1, 2'd3};
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      if (i < 3) begin a = va[i]; b = vb[i]; end
      tick();
      checks++;
      if (sum !== exp_sum || sum_vld !== exp_vld) begin
        errors++;
        $display("FAIL basic step=%0d sum=%0d vld=%b expected sum=%0d vld=%b",
                 i, sum, sum_vld, exp_sum, exp_vld);
      end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < (1 << WIDTH); i++)
      for (int j = 0; j < (1 << WIDTH); j++) begin
        a = WIDTH'(i); b = WIDTH'(j);
        tick();
        checks++;
        if (sum !== exp_sum || sum_vld !== exp_vld) begin
          errors++;
          $display("FAIL sweep a=%0d b=%0d sum=%0d expected %0d", i, j, sum, exp_sum);
        end
      end
    a = 2'd3; b = 2'd3;
    for (int i = 0; i < LAT; i++) tick();
    checks++;
    if (sum !== 3'd6 || sum[WIDTH] !== 1'b1) begin
      errors++;
      $display("FAIL carry_out sum=%0d expected 6 with carry bit set", sum);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      tick();
      checks++;
      if (sum !== exp_sum || sum_vld !== exp_vld) begin
        errors++;
        $display("FAIL random step=%0d sum=%0d vld=%b expected sum=%0d vld=%b",
                 i, sum, sum_vld, exp_sum, exp_vld);
      end
    end
  endtask

  task automatic test_async_reset();
    a = 2'd3; b = 2'd2;
    for (int i = 0; i < LAT; i++) tick();
    checks++;
    if (sum !== 3'd5 || sum_vld !== 1'b1) begin
      errors++;
      $display("FAIL async_pre sum=%0d vld=%b expected sum=5 vld=1", sum, sum_vld);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (sum !== '0 || sum_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_assert sum=%0d vld=%b expected sum=0 vld=0", sum, sum_vld);
    end
    @(posedge clk); #1;
    checks++;
    if (sum !== '0 || sum_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_hold sum=%0d vld=%b expected sum=0 vld=0", sum, sum_vld);
    end
    model_reset();
    #2 rst = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      checks++;
      if (sum !== exp_sum || sum_vld !== exp_vld) begin
        errors++;
        $display("FAIL async_release edge=%0d sum=%0d vld=%b expected sum=%0d vld=%b",
                 edges, sum, sum_vld, exp_sum, exp_vld);
      end
    end
    checks++;
    if (sum !== 3'd5) begin
      errors++;
      $display("FAIL async_result sum=%0d expected 5", sum);
    end
  endtask

  task automatic test_glitch();
    a = 2'd1; b = 2'd1;
    for (int i = 0; i < LAT; i++) tick();
    #1 a = 2'd2;
    #1;
    checks++;
    if (sum !== 3'd2) begin
      errors++;
      $display("FAIL glitch_mid sum=%0d expected 2", sum);
    end
    #1 a = 2'd1;
    #1;
    checks++;
    if (sum !== 3'd2) begin
      errors++;
      $display("FAIL glitch_back sum=%0d expected 2", sum);
    end
    tick();
    checks++;
    if (sum !== exp_sum || sum !== 3'd2) begin
      errors++;
      $display("FAIL glitch_edge sum=%0d expected %0d", sum, exp_sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_random();
    test_async_reset();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
